// File: rtl/commit_unit.sv
// commit_unit: in-order retirement stage.
// Retires the ROB head and keeps the architectural rename map.
// Frees the superseded physical register on each retire.
// A retiring branch triggers a one-cycle flush/redirect, then replays the whole
// architectural map to the rename table.
// Optional feature macro: COMMIT_PERF_CNT_EN enables the retired/flush counters.
// Without it both counter outputs are tied to zero.
module commit_unit #(
  parameter int PHY_W     = 6,
  parameter int ARCH_REGS = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         commit_valid,
  input  logic [$clog2(ARCH_REGS)-1:0] commit_rdst,
  input  logic [PHY_W-1:0]             commit_phydst,
  input  logic [31:0]                  commit_pc,
  input  logic                         commit_branch,
  input  logic [31:0]                  commit_branch_to_pc,
  input  logic                         stall,
  output logic                         check_commit,
  output logic                         flush,
  output logic                         redirect_valid,
  output logic [31:0]                  redirect_pc,
  output logic                         free_valid,
  output logic [PHY_W-1:0]             free_phy,
  output logic                         recover_valid,
  output logic [$clog2(ARCH_REGS)-1:0] recover_idx,
  output logic [PHY_W-1:0]             recover_phy,
  output logic [31:0]                  retired_count,
  output logic [15:0]                  flush_count
);

  localparam int IDX_W = $clog2(ARCH_REGS);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [IDX_W-1:0]  idx_r;
  logic [PHY_W-1:0]  arch_map_r [ARCH_REGS];
  logic              free_valid_r;
  logic [PHY_W-1:0]  free_phy_r;
  logic [31:0]       redirect_pc_r;
  logic              retire_s;
  logic              map_write_s;
  logic              last_beat_s;
  logic              unused_s;

  // The PC is carried by the ROB for debug only; nothing here consumes it.
  assign unused_s = ^commit_pc;

  // Retirement is only possible in RUN; held low while reset is asserted.
  assign retire_s     = rst_n & (state_r == ST_RUN) & commit_valid & ~stall;
  assign map_write_s  = retire_s & (commit_rdst != {IDX_W{1'b0}});
  assign last_beat_s  = (idx_r == IDX_W'(ARCH_REGS - 1));
  assign check_commit = retire_s;

  // Next-state logic: RUN -> FLUSH on branch retire, FLUSH -> RECOVER, RECOVER -> RUN after last beat.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (retire_s && commit_branch) begin
          state_s = ST_FLUSH;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_FLUSH: begin
        state_s = ST_RECOVER;
      end
      ST_RECOVER: begin
        if (last_beat_s) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_RECOVER;
        end
      end
      default: begin
        state_s = ST_RUN;
      end
    endcase
  end

  // State register and recovery beat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_RUN;
      idx_r   <= {IDX_W{1'b0}};
    end else begin
      state_r <= state_s;
      if ((state_r == ST_RECOVER) && !last_beat_s) begin
        idx_r <= idx_r + IDX_W'(1);
      end else begin
        idx_r <= {IDX_W{1'b0}};
      end
    end
  end

  // Architectural map: identity after reset, updated by retiring writers (r0 is never remapped).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        arch_map_r[i] <= PHY_W'(i);
      end
    end else if (map_write_s) begin
      arch_map_r[commit_rdst] <= commit_phydst;
    end
  end

  // Free-list release of the mapping displaced by a retire, and the captured redirect target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      free_valid_r  <= 1'b0;
      free_phy_r    <= {PHY_W{1'b0}};
      redirect_pc_r <= 32'd0;
    end else begin
      free_valid_r <= map_write_s;
      free_phy_r   <= map_write_s ? arch_map_r[commit_rdst] : {PHY_W{1'b0}};
      if (retire_s && commit_branch) begin
        redirect_pc_r <= commit_branch_to_pc;
      end
    end
  end

  assign free_valid     = free_valid_r;
  assign free_phy       = free_phy_r;
  assign flush          = (state_r == ST_FLUSH);
  assign redirect_valid = (state_r == ST_FLUSH);
  assign redirect_pc    = (state_r == ST_FLUSH) ? redirect_pc_r : 32'd0;
  assign recover_valid  = (state_r == ST_RECOVER);
  assign recover_idx    = (state_r == ST_RECOVER) ? idx_r : {IDX_W{1'b0}};
  assign recover_phy    = (state_r == ST_RECOVER) ? arch_map_r[idx_r] : {PHY_W{1'b0}};

`ifdef COMMIT_PERF_CNT_EN
  logic [31:0] retired_cnt_r;
  logic [15:0] flush_cnt_r;

  // Performance counters: retires and flushes, both free-running with wraparound.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_cnt_r <= 32'd0;
      flush_cnt_r   <= 16'd0;
    end else begin
      if (retire_s) begin
        retired_cnt_r <= retired_cnt_r + 32'd1;
      end
      if (state_r == ST_FLUSH) begin
        flush_cnt_r <= flush_cnt_r + 16'd1;
      end
    end
  end

  assign retired_count = retired_cnt_r;
  assign flush_count   = flush_cnt_r;
`else
  assign retired_count = 32'd0;
  assign flush_count   = 16'd0;
`endif

endmodule

// File: doc/commit_unit.md
COMMIT_UNIT -- requirements
Module: Commit_Unit

Interface
REQ-001 SHALL have parameter PHY_W, default 6, physical-register index width.
REQ-002 SHALL have parameter ARCH_REGS, default 32, architectural register count (Rdst width $clog2(ARCH_REGS)).
REQ-003 SHALL have port System.Clk  in  1  single clock, all state on rising edge (System is the Global struct).
REQ-004 SHALL have port System.Rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port Commit_Valid  in  1  ROB head entry valid and completed.
REQ-006 SHALL have port Commit_Rdst  in  5  architectural destination of head entry.
REQ-007 SHALL have port Commit_Phydst  in  PHY_W  physical destination of head entry.
REQ-008 SHALL have port Commit_PC  in  32  PC of head entry.
REQ-009 SHALL have port Commit_Branch  in  1  head entry requires redirect.
REQ-010 SHALL have port Commit_Branch_To_PC  in  32  redirect target.
REQ-011 SHALL have port Stall  in  1  hold retirement.
REQ-012 SHALL have port Check_Commit  out  1  retire head this cycle; advances ROB read pointer.
REQ-013 SHALL have port Flush  out  1  pipeline flush pulse.
REQ-014 SHALL have ports Redirect_Valid  out  1 and Redirect_PC  out  32  fetch redirect.
REQ-015 SHALL have ports Free_Valid  out  1 and Free_Phy  out  PHY_W  released physical register.
REQ-016 SHALL have ports Recover_Valid  out  1, Recover_Idx  out  5, Recover_Phy  out  PHY_W  rename-table restore stream.
REQ-017 SHALL have ports Retired_Count  out  32 and Flush_Count  out  16.

Function
REQ-018 SHALL hold architectural map Arch_Map[ARCH_REGS] of PHY_W-bit entries.
REQ-019 SHALL implement FSM states RUN, FLUSH, RECOVER.
REQ-020 In RUN, Check_Commit SHALL be combinational: Commit_Valid & ~Stall; 0 in FLUSH/RECOVER.
REQ-021 On retire with Commit_Rdst!=0, Arch_Map[Rdst] SHALL take Commit_Phydst at the edge; next cycle Free_Valid=1, Free_Phy=previous Arch_Map[Rdst].
REQ-022 On retire with Commit_Rdst==0, Arch_Map SHALL be unchanged and Free_Valid SHALL stay 0.
REQ-023 On retire with Commit_Branch=1, FSM SHALL go RUN->FLUSH; no other transition out of RUN.
REQ-024 In FLUSH (exactly one cycle): Flush=1, Redirect_Valid=1, Redirect_PC=registered Commit_Branch_To_PC of the retiring branch; then ->RECOVER.
REQ-025 In RECOVER, SHALL emit ARCH_REGS consecutive beats, Recover_Idx 0..ARCH_REGS-1, Recover_Phy=Arch_Map[Idx] (including the branch's own update), Recover_Valid=1; after last beat ->RUN.
REQ-026 Commit_Valid and Stall SHALL be ignored outside RUN.
REQ-027 Flush, Redirect_Valid, Free_Valid, Recover_Valid SHALL be single-cycle pulses per event.
REQ-028 Retired_Count SHALL increment by 1 per Check_Commit; Flush_Count by 1 per FLUSH; both wrap modulo 2^width.
REQ-029 Stall=1 with Commit_Valid=1 SHALL produce no Check_Commit, no map change.

Reset
REQ-030 On System.Rst low, SHALL asynchronously set FSM=RUN, Arch_Map[i]=i, counters=0, all outputs 0.
REQ-031 Reset asserted mid-RECOVER SHALL abort the stream; first cycle after release SHALL be RUN with identity map.

Configuration
REQ-032 With COMMIT_PERF_CNT_EN defined, Retired_Count/Flush_Count SHALL operate per REQ-028; without it, counters SHALL not be instantiated and both outputs SHALL be constant 0.

Verification
REQ-033 Reset release, Commit_Valid=1, Rdst=5, Phydst=40 -> Check_Commit=1; next cycle Free_Valid=1, Free_Phy=5; Arch_Map[5]=40.
REQ-034 Commit_Valid=1, Rdst=0, Phydst=12 -> Check_Commit=1, Free_Valid stays 0, Arch_Map[0]=0.
REQ-035 Branch retire Rdst=3, Phydst=33, Branch_To_PC=0x0040_0100 -> next cycle Flush=1, Redirect_PC=0x0040_0100; then 32 Recover beats, beat 3 Recover_Phy=33, Check_Commit=0 throughout; then RUN.
REQ-036 Stall=1 for 4 cycles with Commit_Valid=1 -> Check_Commit=0 all 4 cycles; Retired_Count unchanged.
REQ-037 Assert System.Rst low at RECOVER beat 10 -> Recover_Valid=0 immediately; after release Arch_Map identity, state RUN.
REQ-038 With COMMIT_PERF_CNT_EN, 3 retires + 1 branch retire -> Retired_Count=4, Flush_Count=1; without macro both read 0.
